// File: rtl/dispatcher_pkg.sv
// Shared types and constants for the SRAM mailbox pixel dispatcher.
// Holds the FSM state encoding, mailbox address map and entry field positions.
package dispatcher_pkg;

    typedef enum logic [2:0] {
        ST_POLL,
        ST_COUNT,
        ST_FETCH,
        ST_REQ,
        ST_RELEASE,
        ST_NEXT,
        ST_CLEAR
    } state_t;

    // Mailbox address map
    localparam int unsigned ADDR_READY = 0;
    localparam int unsigned ADDR_COUNT = 1;
    localparam int unsigned ADDR_BASE  = 2;

    // Entry field LSB positions
    localparam int unsigned X_LSB = 20;
    localparam int unsigned Y_LSB = 8;
    localparam int unsigned V_LSB = 0;

    localparam int unsigned CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mailbox_reader.sv
// Single outstanding SRAM read: waits RD_LAT cycles after the address is
// presented, then captures readdata and pulses rd_valid for one cycle.
module mailbox_reader #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rd_start,
    input  logic [31:0] sram_readdata,
    output logic        rd_valid,
    output logic [31:0] rd_data
);

    localparam int unsigned LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    logic             active;
    logic [LAT_W-1:0] lat_cnt;

    // The address register updates on the same edge rd_start is seen
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            lat_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_start) begin
                active  <= 1'b1;
                lat_cnt <= LAT_W'(RD_LAT);
            end else if (active) begin
                if (lat_cnt == '0) begin
                    active   <= 1'b0;
                    rd_valid <= 1'b1;
                    rd_data  <= sram_readdata;
                end else begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sram_pixel_dispatcher.sv
// Drains an HPS-posted point list from the SRAM mailbox, dispatching each
// point to its column writer over a 4-phase select/return handshake.
module sram_pixel_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int unsigned NCOLS      = 64,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned SRAM_AW    = 8,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned HS_TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               const_mode,
    input  logic [PIX_W-1:0]   const_color,
    output logic [SRAM_AW-1:0] sram_address,
    output logic               sram_write,
    output logic [31:0]        sram_writedata,
    input  logic [31:0]        sram_readdata,
    output logic [NCOLS-1:0]   col_select,
    output logic [Y_W-1:0]     row_select,
    output logic [PIX_W-1:0]   pixel_color,
    input  logic [NCOLS-1:0]   return_sig,
    output logic               busy,
    output logic               list_done,
    output logic [15:0]        drop_count
);

    localparam int unsigned COL_W = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int unsigned TMR_W = $clog2(HS_TIMEOUT + 1);
    localparam int unsigned MAX_N = (1 << SRAM_AW) - 2;

    state_t             state;
    logic               rd_issued;
    logic               rd_start_c;
    logic               rd_valid;
    logic [31:0]        rd_data;
    logic [SRAM_AW-1:0] rd_addr_c;
    logic [SRAM_AW-1:0] n_entries;
    logic [SRAM_AW-1:0] idx;
    logic [COL_W-1:0]   col;
    logic [TMR_W-1:0]   timer;

    logic [X_W-1:0]     ent_x_c;
    logic [Y_W-1:0]     ent_y_c;
    logic [PIX_W-1:0]   ent_v_c;
    logic [SRAM_AW-1:0] ent_n_c;
    logic               x_in_range_c;
    logic               ack_c;
    logic               timeout_c;

    assign sram_writedata = '0;

    assign ent_x_c      = rd_data[X_LSB +: X_W];
    assign ent_y_c      = rd_data[Y_LSB +: Y_W];
    assign ent_v_c      = rd_data[V_LSB +: PIX_W];
    assign ent_n_c      = (rd_data[SRAM_AW-1:0] > SRAM_AW'(MAX_N)) ? SRAM_AW'(MAX_N)
                                                                   : rd_data[SRAM_AW-1:0];
    assign x_in_range_c = (32'(ent_x_c) < NCOLS);
    assign ack_c        = return_sig[col];
    assign timeout_c    = (timer == TMR_W'(HS_TIMEOUT - 1));

    // One read per visit to a read state; enable gates only the idle poll
    assign rd_start_c = !rd_issued &&
                        ((state == ST_POLL && enable) || state == ST_COUNT || state == ST_FETCH);

    always_comb begin
        rd_addr_c = SRAM_AW'(ADDR_READY);
        case (state)
            ST_COUNT: rd_addr_c = SRAM_AW'(ADDR_COUNT);
            ST_FETCH: rd_addr_c = SRAM_AW'(ADDR_BASE) + idx;
            default:  rd_addr_c = SRAM_AW'(ADDR_READY);
        endcase
    end

    mailbox_reader #(
        .RD_LAT (RD_LAT)
    ) u_reader (
        .clock         (clock),
        .reset_n       (reset_n),
        .rd_start      (rd_start_c),
        .sram_readdata (sram_readdata),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_POLL;
            rd_issued    <= 1'b0;
            sram_address <= '0;
            sram_write   <= 1'b0;
            col_select   <= '0;
            row_select   <= '0;
            pixel_color  <= '0;
            busy         <= 1'b0;
            list_done    <= 1'b0;
            drop_count   <= '0;
            n_entries    <= '0;
            idx          <= '0;
            col          <= '0;
            timer        <= '0;
        end else begin
            sram_write <= 1'b0;
            list_done  <= 1'b0;
            if (rd_start_c) begin
                rd_issued    <= 1'b1;
                sram_address <= rd_addr_c;
            end
            if (rd_valid) begin
                rd_issued <= 1'b0;
            end

            case (state)
                ST_POLL: begin
                    if (rd_valid && rd_data != '0 && enable) begin
                        state <= ST_COUNT;
                        busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (rd_valid) begin
                        n_entries <= ent_n_c;
                        idx       <= '0;
                        if (ent_n_c == '0) begin
                            state        <= ST_CLEAR;
                            sram_write   <= 1'b1;
                            list_done    <= 1'b1;
                            sram_address <= SRAM_AW'(ADDR_READY);
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (rd_valid) begin
                        idx <= idx + SRAM_AW'(1);
                        if (x_in_range_c) begin
                            col         <= COL_W'(ent_x_c);
                            col_select  <= NCOLS'(1) << COL_W'(ent_x_c);
                            row_select  <= ent_y_c;
                            pixel_color <= const_mode ? const_color : ent_v_c;
                            timer       <= '0;
                            state       <= ST_REQ;
                        end else begin
                            drop_count <= sat_inc(drop_count);
                            state      <= ST_NEXT;
                        end
                    end
                end
                ST_REQ: begin
                    if (ack_c) begin
                        col_select <= '0;
                        timer      <= '0;
                        state      <= ST_RELEASE;
                    end else if (timeout_c) begin
                        col_select <= '0;
                        drop_count <= sat_inc(drop_count);
                        state      <= ST_NEXT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                // Waiting for the ack to fall keeps a held ack from satisfying the next point
                ST_RELEASE: begin
                    if (!ack_c) begin
                        state <= ST_NEXT;
                    end else if (timeout_c) begin
                        drop_count <= sat_inc(drop_count);
                        state      <= ST_NEXT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (idx == n_entries) begin
                        state        <= ST_CLEAR;
                        sram_write   <= 1'b1;
                        list_done    <= 1'b1;
                        sram_address <= SRAM_AW'(ADDR_READY);
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_CLEAR: begin
                    busy  <= 1'b0;
                    state <= ST_POLL;
                end
                default: state <= ST_POLL;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_pixel_dispatcher.sv
// Bench for sram_pixel_dispatcher: SRAM mailbox and column-writer models,
// with a list-level reference model of the expected dispatches and drops.
module tb_sram_pixel_dispatcher;

    localparam int unsigned NCOLS      = 64;
    localparam int unsigned X_W        = 10;
    localparam int unsigned Y_W        = 10;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned SRAM_AW    = 8;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned HS_TIMEOUT = 15;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b0;
    logic               const_mode = 1'b0;
    logic [PIX_W-1:0]   const_color = '0;
    logic [SRAM_AW-1:0] sram_address;
    logic               sram_write;
    logic [31:0]        sram_writedata;
    logic [31:0]        sram_readdata;
    logic [NCOLS-1:0]   col_select;
    logic [Y_W-1:0]     row_select;
    logic [PIX_W-1:0]   pixel_color;
    logic [NCOLS-1:0]   return_sig = '0;
    logic               busy;
    logic               list_done;
    logic [15:0]        drop_count;

    sram_pixel_dispatcher #(
        .NCOLS (NCOLS), .X_W (X_W), .Y_W (Y_W), .PIX_W (PIX_W),
        .SRAM_AW (SRAM_AW), .RD_LAT (RD_LAT), .HS_TIMEOUT (HS_TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .const_mode     (const_mode),
        .const_color    (const_color),
        .sram_address   (sram_address),
        .sram_write     (sram_write),
        .sram_writedata (sram_writedata),
        .sram_readdata  (sram_readdata),
        .col_select     (col_select),
        .row_select     (row_select),
        .pixel_color    (pixel_color),
        .return_sig     (return_sig),
        .busy           (busy),
        .list_done      (list_done),
        .drop_count     (drop_count)
    );

    always #5 clock = ~clock;

    // SRAM: registered read pipeline of depth RD_LAT
    logic [31:0] mem  [256];
    logic [31:0] pipe [RD_LAT];
    always @(posedge clock) begin
        pipe[0] <= mem[sram_address];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sram_readdata = pipe[RD_LAT-1];

    typedef struct {
        int         col;
        logic [9:0] row;
        logic [7:0] color;
        int         hi;
    } req_t;

    req_t        obs_q[$];
    req_t        exp_q[$];
    req_t        cur;
    int          wr_phase = 0, wait_cnt = 0, hold_cnt = 0, cur_col = 0;
    int          ack_target = 0, hold_target = 0;
    int          ack_max = 3, hold_lo = 0, hold_hi = 3;
    bit          noise_en = 1'b0;
    logic [63:0] dead_mask = '0;
    int          onehot_bad = 0, stab_bad = 0, busy_bad = 0, clear_bad = 0, done_cnt = 0;
    int          exp_drops_total = 0;
    int          n_pass = 0, n_total = 0;

    // Column writers: dead columns never ack; others ack after a random delay
    always @(negedge clock) begin
        if (!reset_n) begin
            return_sig = '0;
            wr_phase   = 0;
        end else begin
            case (wr_phase)
                0: if (col_select != '0) begin
                    if ($countones(col_select) != 1) onehot_bad++;
                    cur_col = 0;
                    for (int i = 0; i < NCOLS; i++) if (col_select[i]) cur_col = i;
                    cur.col     = cur_col;
                    cur.row     = row_select;
                    cur.color   = pixel_color;
                    cur.hi      = 1;
                    ack_target  = $urandom_range(ack_max, 0);
                    hold_target = $urandom_range(hold_hi, hold_lo);
                    wait_cnt    = 0;
                    wr_phase    = 1;
                end
                1: if (col_select == '0) begin
                    return_sig = '0;
                    obs_q.push_back(cur);
                    wr_phase = 0;
                end else begin
                    cur.hi++;
                    if (col_select != (NCOLS'(1) << cur_col) || row_select != cur.row ||
                        pixel_color != cur.color) stab_bad++;
                    if (!dead_mask[cur_col] && wait_cnt >= ack_target) begin
                        return_sig          = '0;
                        return_sig[cur_col] = 1'b1;
                        obs_q.push_back(cur);
                        wr_phase = 2;
                    end else begin
                        wait_cnt++;
                        if (noise_en) return_sig[(cur_col + 1) % NCOLS] = 1'b1;
                    end
                end
                2: if (col_select == '0) begin
                    hold_cnt = 0;
                    wr_phase = 3;
                end
                3: if (hold_cnt >= hold_target) begin
                    return_sig = '0;
                    wr_phase   = 0;
                end else begin
                    hold_cnt++;
                end
                default: wr_phase = 0;
            endcase
        end
    end

    // Mailbox write-back and protocol monitor
    always @(negedge clock) begin
        if (reset_n) begin
            if (sram_write) mem[sram_address] = sram_writedata;
            if (list_done) begin
                done_cnt++;
                if (!(sram_write && sram_address == '0 && sram_writedata == '0 && busy)) clear_bad++;
            end else if (sram_write) begin
                clear_bad++;
            end
            if (col_select != '0 && !busy) busy_bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk(input int x, input int y, input int v);
        return (32'(x) << 20) | (32'(y) << 8) | 32'(v) | ($urandom & 32'hC00C_0000);
    endfunction

    // Reference: walk the posted list and predict dispatches and drops
    function automatic void build_expected();
        int          n;
        int          x;
        logic [31:0] e;
        req_t        r;
        exp_q.delete();
        n = int'(mem[1] & 32'hFF);
        if (n > 254) n = 254;
        for (int i = 0; i < n; i++) begin
            e = mem[2 + i];
            x = int'((e >> 20) & 32'h3FF);
            if (x >= 64) begin
                exp_drops_total++;
            end else begin
                r.col   = x;
                r.row   = e[17:8];
                r.color = const_mode ? const_color : e[7:0];
                r.hi    = dead_mask[x] ? int'(HS_TIMEOUT) : -1;
                if (dead_mask[x]) exp_drops_total++;
                exp_q.push_back(r);
            end
        end
    endfunction

    task automatic start_list();
        build_expected();
        obs_q.delete();
        done_cnt = 0;
        mem[0]   = $urandom | 32'h1;
    endtask

    task automatic finish_list(input string tag);
        int cyc;
        int m;
        cyc = 0;
        while (mem[0] != 0 && cyc < 30000) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_mbox_cleared"}, 64'(mem[0]), 64'h0);
        repeat (3) @(negedge clock);
        check({tag, "_list_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        check({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drops_total));
        check({tag, "_protocol"}, 64'(onehot_bad + stab_bad + busy_bad + clear_bad), 64'd0);
        check({tag, "_n_requests"}, 64'(obs_q.size()), 64'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_col"}, 64'(obs_q[i].col), 64'(exp_q[i].col));
            check({tag, "_row"}, 64'(obs_q[i].row), 64'(exp_q[i].row));
            check({tag, "_color"}, 64'(obs_q[i].color), 64'(exp_q[i].color));
            if (exp_q[i].hi >= 0) check({tag, "_timeout_len"}, 64'(obs_q[i].hi), 64'(exp_q[i].hi));
        end
    endtask

    initial begin
        bit ok;
        int n;
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_col_select", 64'(col_select), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_outputs", 64'({sram_write, list_done, sram_address, row_select, pixel_color}), 64'h0);
        check("rst_drop_count", 64'(drop_count), 64'h0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Empty mailbox: only ready-word polling
        ok = 1'b1;
        repeat (50) begin
            @(negedge clock);
            if (sram_address != '0 || busy || col_select != '0 || sram_write) ok = 1'b0;
        end
        check("idle_poll_only", 64'(ok), 64'd1);

        // Directed three-point list
        mem[1] = 32'd3;
        mem[2] = mk(5, 7, 8'h20);
        mem[3] = mk(63, 0, 8'hFF);
        mem[4] = mk(0, 479, 8'h01);
        start_list();
        finish_list("basic");

        // Constant colour mode
        const_mode  = 1'b1;
        const_color = 8'hAA;
        mem[1] = 32'd2;
        mem[2] = mk(17, 100, 8'h12);
        mem[3] = mk(40, 3, 8'h34);
        start_list();
        finish_list("const");
        const_mode = 1'b0;

        // Out-of-range column dropped
        mem[1] = 32'd2;
        mem[2] = mk(70, 5, 8'h55);
        mem[3] = mk(64'd1, 6, 8'h66);
        start_list();
        finish_list("oob");

        // Writer never acks: timeout drop, list still completes
        dead_mask = 64'h0;
        dead_mask[9] = 1'b1;
        mem[1] = 32'd2;
        mem[2] = mk(9, 11, 8'h77);
        mem[3] = mk(10, 12, 8'h78);
        start_list();
        finish_list("timeout");
        dead_mask = '0;

        // Held ack blocks the next fetch
        ack_max = 0; hold_lo = 10; hold_hi = 10;
        mem[1] = 32'd2;
        mem[2] = mk(5, 1, 8'h11);
        mem[3] = mk(12, 2, 8'h22);
        start_list();
        cyc = 0;
        while (wr_phase != 3 && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        check("hold_reached", 64'(wr_phase), 64'd3);
        ok = 1'b1;
        repeat (9) begin
            @(negedge clock);
            if (sram_address != 8'd2 || col_select != '0 || !busy || !return_sig[5] || obs_q.size() != 1)
                ok = 1'b0;
        end
        check("hold_no_fetch", 64'(ok), 64'd1);
        finish_list("hold");
        ack_max = 3; hold_lo = 0; hold_hi = 3;

        // Empty list
        mem[1] = 32'hFFFF_FF00;
        start_list();
        finish_list("empty");

        // enable=0 ignores a posted list until re-enabled
        @(negedge clock);
        enable = 1'b0;
        repeat (4) @(negedge clock);
        mem[1] = 32'd1;
        mem[2] = mk(33, 44, 8'h5A);
        start_list();
        ok = 1'b1;
        repeat (30) begin
            @(negedge clock);
            if (busy || col_select != '0) ok = 1'b0;
        end
        check("disabled_idle", 64'(ok), 64'd1);
        enable = 1'b1;
        finish_list("reenable");

        // Randomised lists with noise, random writer timing and dead columns
        ack_max = 8; hold_lo = 0; hold_hi = 8;
        for (int l = 0; l < 6; l++) begin
            n = $urandom_range(12, 1);
            mem[1] = ($urandom & 32'hFFFF_FF00) | 32'(n);
            for (int i = 0; i < n; i++)
                mem[2 + i] = mk($urandom_range(79, 0), $urandom_range(1023, 0), $urandom_range(255, 0));
            const_mode  = 1'($urandom_range(1, 0));
            const_color = 8'($urandom);
            dead_mask   = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            noise_en    = 1'($urandom_range(1, 0));
            start_list();
            finish_list("rand");
        end
        const_mode = 1'b0; dead_mask = '0; noise_en = 1'b0;

        // Count above capacity is clamped to 254 entries
        ack_max = 1; hold_lo = 0; hold_hi = 1;
        mem[1] = 32'hABCD_01FF;
        for (int i = 0; i < 254; i++)
            mem[2 + i] = mk($urandom_range(70, 0), $urandom_range(1023, 0), $urandom_range(255, 0));
        mem[255] = mk(3, 3, 8'h33);
        start_list();
        check("clamp_model_len_ok", 64'(exp_q.size() <= 254), 64'd1);
        finish_list("clamp");

        // Reset mid-request abandons the list, mailbox untouched
        dead_mask[9] = 1'b1;
        mem[1] = 32'd1;
        mem[2] = mk(9, 9, 8'h99);
        start_list();
        cyc = 0;
        while (col_select == '0 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("rst_mid_reached_req", 64'(col_select != '0), 64'd1);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_col_select", 64'(col_select), 64'h0);
        check("rst_mid_busy", 64'(busy), 64'h0);
        check("rst_mid_outputs", 64'({sram_write, list_done, sram_address, row_select, pixel_color}), 64'h0);
        check("rst_mid_drop_count", 64'(drop_count), 64'h0);
        check("rst_mid_mbox_kept", 64'(mem[0] != 0), 64'd1);
        enable = 1'b0;
        exp_drops_total = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("rst_after_idle", 64'({busy, col_select != '0}), 64'h0);
        check("rst_after_mbox_kept", 64'(mem[0] != 0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
